// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared types and constants for the MIPS memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  typedef enum logic {LOAD, SERVE} mem_state_t;

  localparam int MEM_DEPTH_DEFAULT = 128;
  localparam int MEM_WORD_W        = 32;

endpackage

`default_nettype wire

// File: rtl/mips_mem_array.sv
// ============================================================================
// Module      : mips_mem_array
// Description : Word storage, one write port and one synchronous read port,
//               read-before-write, contents survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [MEM_WORD_W-1:0] o_rdata
);

  logic [MEM_WORD_W-1:0] r_mem [DEPTH];
  logic [MEM_WORD_W-1:0] r_rdata;

  // Both updates on the same edge: a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module      : mips_mem_responder
// Description : Preloadable word memory serving the MIPS external memory
//               interface with range checking and access counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [MEM_WORD_W-1:0] writedata,
  output logic [MEM_WORD_W-1:0] memdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_addr,
  input  logic [MEM_WORD_W-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  run,
  output logic                  oob_err,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
);

  localparam logic [31:0] c_depth = 32'(DEPTH);

  mem_state_t            r_state;
  mem_state_t            w_state_nxt;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [MEM_WORD_W-1:0] w_wdata;
  logic                  w_in_range;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_re;
  logic [MEM_WORD_W-1:0] w_rdata;
  logic                  r_zero;
  logic                  r_oob;
  logic [CNT_W-1:0]      r_rd_count;
  logic [CNT_W-1:0]      r_wr_count;

  assign w_in_range = (addr < c_depth);
  assign w_rd_acc   = (r_state == SERVE) && memread;
  assign w_wr_acc   = (r_state == SERVE) && memwrite;
  assign w_re       = w_rd_acc && w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // Write-source mux: preload channel in LOAD, processor port in SERVE.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = ld_addr;
    w_wdata     = ld_data;
    case (r_state)
      LOAD: begin
        w_we = ld_valid;
        if (ld_valid && ld_last) w_state_nxt = SERVE;
      end
      SERVE: begin
        w_we    = w_wr_acc && w_in_range;
        w_waddr = addr[AW-1:0];
        w_wdata = writedata;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  mips_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (addr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // The array read register has no reset, so r_zero forces memdata to zero
  // after reset and after an out-of-range read until the next valid read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero     <= 1'b1;
      r_oob      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_acc) begin
        r_zero <= !w_in_range;
        if (r_rd_count != '1) r_rd_count <= r_rd_count + CNT_W'(1);
      end
      if (w_wr_acc && (r_wr_count != '1)) r_wr_count <= r_wr_count + CNT_W'(1);
      if ((w_rd_acc || w_wr_acc) && !w_in_range) r_oob <= 1'b1;
    end
  end

  assign memdata  = r_zero ? '0 : w_rdata;
  assign ld_ready = (r_state == LOAD);
  assign run      = (r_state == SERVE);
  assign oob_err  = r_oob;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

`default_nettype wire
